// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the MULT/DIV sequencer.
package muldiv_pkg;

  localparam int WIDTH = 32;

  // Index of the final iteration step (32 steps counted 0..31)
  localparam logic [4:0] STEP_LAST = 5'd31;

  // 2-bit state encoding kept as plain constants for compatibility with older tools
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MULT = 2'b01;
  localparam logic [1:0] ST_DIV  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // Working registers of the restoring divider: partial remainder and shifting quotient
  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
  } div_state_t;

  // Magnitude of a signed word; -2^31 maps to 0x80000000, which is exact as unsigned
  function automatic logic [WIDTH-1:0] abs32(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (32'd0 - v) : v;
  endfunction

  // Re-apply a sign to an unsigned magnitude
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? (32'd0 - mag) : mag;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the main control FSM and the MULT/DIV sequencer.
interface muldiv_ctrl_if;
  import muldiv_pkg::*;

  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  // The main control FSM issues requests and consumes results
  modport master (
    output start_mult, start_div, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  // The sequencer receives requests and presents results
  modport slave (
    input  start_mult, start_div, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out
  );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division step: shift {rem, quo} left, trial subtract, set quotient bit.
module div_step
  import muldiv_pkg::*;
(
  input  div_state_t        cur,
  input  logic [WIDTH:0]    divisor,
  output div_state_t        nxt
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The remainder always stays below the divisor (<= 2^31), so a 32-bit difference is exact when it fits
  always_comb begin
    shifted  = {cur.rem, cur.quo[WIDTH-1]};
    fits     = (shifted >= divisor);
    diff     = shifted[WIDTH-1:0] - divisor[WIDTH-1:0];
    nxt.rem  = fits ? diff : shifted[WIDTH-1:0];
    nxt.quo  = {cur.quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multicycle signed multiply (radix-2 Booth) and signed restoring divide sequencer.
// Results live in hi/lo output registers that only change on completion; all
// iteration happens in shadow registers.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);

  logic [1:0]        state;
  logic [4:0]        count;
  logic              busy_q;
  logic              done_q;
  logic              div_zero_q;
  logic              dz_pend;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  // Multiply shadow: multiplicand and the 65-bit {hi, lo, q-1} product register
  logic [WIDTH-1:0]  mcand;
  logic [2*WIDTH:0]  prod;
  logic [WIDTH:0]    booth_sum;
  logic [2*WIDTH:0]  prod_next;

  // Divide shadow: magnitudes and the result signs
  div_state_t        dacc;
  div_state_t        dacc_next;
  logic [WIDTH:0]    dvsr;
  logic              q_neg;
  logic              r_neg;

  // Booth step: add/subtract the sign-extended multiplicand into hi, then arithmetic shift right
  always_comb begin
    booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    case (prod[1:0])
      2'b01:   booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    endcase
    prod_next = {booth_sum, prod[WIDTH:1]};
  end

  div_step u_div_step (
    .cur     (dacc),
    .divisor (dvsr),
    .nxt     (dacc_next)
  );

  // Sequencer FSM plus shadow datapath; outputs are only loaded on completion
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      dz_pend    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand      <= '0;
      prod       <= '0;
      dacc       <= '0;
      dvsr       <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (bus.start_mult) begin
            state  <= ST_MULT;
            busy_q <= 1'b1;
            mcand  <= bus.a_in;
            prod   <= {32'd0, bus.b_in, 1'b0};
          end else if (bus.start_div) begin
            busy_q   <= 1'b1;
            q_neg    <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            r_neg    <= bus.a_in[WIDTH-1];
            dacc.rem <= '0;
            dacc.quo <= abs32(bus.a_in);
            dvsr     <= {1'b0, abs32(bus.b_in)};
            if (bus.b_in == '0) begin
              state   <= ST_DONE;
              dz_pend <= 1'b1;
            end else begin
              state   <= ST_DIV;
            end
          end
        end

        ST_MULT: begin
          prod  <= prod_next;
          count <= count + 5'd1;
          if (count == STEP_LAST) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            hi_q   <= prod_next[2*WIDTH:WIDTH+1];
            lo_q   <= prod_next[WIDTH:1];
          end
        end

        ST_DIV: begin
          dacc  <= dacc_next;
          count <= count + 5'd1;
          if (count == STEP_LAST) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            hi_q   <= apply_sign(dacc_next.rem, r_neg);
            lo_q   <= apply_sign(dacc_next.quo, q_neg);
          end
        end

        ST_DONE: begin
          if (dz_pend) begin
            dz_pend    <= 1'b0;
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
          end else begin
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for the MULT/DIV sequencer.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   vecCount = 0;
  int   errCount = 0;
  int   doneSeen;

  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  // Single comparison point: counts every vector and reports a miscompare
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a one-cycle start; returns 1 unit after the accepting edge E0
  task automatic applyStimulus(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.a_in       = a;
    bus.b_in       = b;
    @(posedge clock);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in       = 32'hDEAD_BEEF;
    bus.b_in       = 32'h1234_5678;
  endtask

  // Follow a 32-step operation from just after E0 through E33
  task automatic expectResult(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] prevHi;
    logic [31:0] prevLo;
    prevHi = bus.hi_out;
    prevLo = bus.lo_out;
    checkOutput({tag, " busy@E0"}, bus.busy, 32'd1);
    repeat (31) @(posedge clock);
    #1;
    checkOutput({tag, " done@E31"}, bus.done, 32'd0);
    checkOutput({tag, " hi held"}, bus.hi_out, prevHi);
    checkOutput({tag, " lo held"}, bus.lo_out, prevLo);
    @(posedge clock);
    #1;
    checkOutput({tag, " done@E32"}, bus.done, 32'd1);
    checkOutput({tag, " dz@E32"}, bus.div_zero, 32'd0);
    checkOutput({tag, " hi"}, bus.hi_out, expHi);
    checkOutput({tag, " lo"}, bus.lo_out, expLo);
    @(posedge clock);
    #1;
    checkOutput({tag, " done@E33"}, bus.done, 32'd0);
    checkOutput({tag, " busy@E33"}, bus.busy, 32'd0);
  endtask

  // Directed scenario sequence
  initial begin
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    reset          = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst busy", bus.busy, 32'd0);
    checkOutput("rst done", bus.done, 32'd0);
    checkOutput("rst dz", bus.div_zero, 32'd0);
    checkOutput("rst hi", bus.hi_out, 32'd0);
    checkOutput("rst lo", bus.lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    expectResult("mul 7*-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    expectResult("mul min*min", 32'h4000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    expectResult("div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    expectResult("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    expectResult("div min/-1", 32'h0000_0000, 32'h8000_0000);

    applyStimulus(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0002);
    expectResult("div 5/2", 32'h0000_0001, 32'h0000_0002);

    // Divide by zero: pulse between E1 and E2, results untouched
    applyStimulus(1'b0, 1'b1, 32'h0000_0009, 32'h0000_0000);
    checkOutput("dz busy@E0", bus.busy, 32'd1);
    checkOutput("dz done@E0", bus.done, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("dz done@E1", bus.done, 32'd1);
    checkOutput("dz flag@E1", bus.div_zero, 32'd1);
    checkOutput("dz busy@E1", bus.busy, 32'd1);
    checkOutput("dz hi kept", bus.hi_out, 32'h0000_0001);
    checkOutput("dz lo kept", bus.lo_out, 32'h0000_0002);
    @(posedge clock);
    #1;
    checkOutput("dz done@E2", bus.done, 32'd0);
    checkOutput("dz flag@E2", bus.div_zero, 32'd0);
    checkOutput("dz busy@E2", bus.busy, 32'd0);

    // Both starts together: multiply wins (6*7=42; a divide would give hi=6, lo=0)
    applyStimulus(1'b1, 1'b1, 32'h0000_0006, 32'h0000_0007);
    expectResult("both->mul", 32'h0000_0000, 32'h0000_002A);

    // A divide-by-zero start at E5 must be ignored entirely
    applyStimulus(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004);
    repeat (4) @(posedge clock);
    #1;
    bus.start_div = 1'b1;
    bus.a_in      = 32'h0000_0064;
    bus.b_in      = 32'h0000_0000;
    @(posedge clock);
    #1;
    bus.start_div = 1'b0;
    repeat (26) @(posedge clock);
    #1;
    checkOutput("ign done@E31", bus.done, 32'd0);
    checkOutput("ign lo held", bus.lo_out, 32'h0000_002A);
    @(posedge clock);
    #1;
    checkOutput("ign done@E32", bus.done, 32'd1);
    checkOutput("ign dz@E32", bus.div_zero, 32'd0);
    checkOutput("ign hi", bus.hi_out, 32'h0000_0000);
    checkOutput("ign lo", bus.lo_out, 32'h0000_000C);
    @(posedge clock);
    #1;
    checkOutput("ign done@E33", bus.done, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("ign no requeue", bus.busy, 32'd0);

    // Reset mid-multiply at E10
    applyStimulus(1'b1, 1'b0, 32'h0000_0009, 32'h0000_0009);
    repeat (9) @(posedge clock);
    #1;
    checkOutput("mrst busy@E9", bus.busy, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mrst busy", bus.busy, 32'd0);
    checkOutput("mrst done", bus.done, 32'd0);
    checkOutput("mrst dz", bus.div_zero, 32'd0);
    checkOutput("mrst hi", bus.hi_out, 32'd0);
    checkOutput("mrst lo", bus.lo_out, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.done) doneSeen++;
    end
    checkOutput("mrst no done", doneSeen, 32'd0);
    checkOutput("mrst idle", bus.busy, 32'd0);

    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    expectResult("post-rst -5*-5", 32'h0000_0000, 32'h0000_0019);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
